// File: rtl/axis_cmd_parser.sv
// rtl/axis_cmd_parser.sv - header-word command parser driving a downstream transfer engine
// Optional feature macro: CMD_CHECKSUM_EN (adds a fifth XOR checksum header word).
module axis_cmd_parser #(
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [7:0]            Instruction_code,
  output logic [4:0]            wr_bram_start,
  output logic [4:0]            wr_bram_end,
  output logic [15:0]           wr_addr_start,
  output logic [15:0]           wr_addr_count,
  output logic [2:0]            rd_bram_start,
  output logic [2:0]            rd_bram_end,
  output logic [15:0]           rd_addr_start,
  output logic [15:0]           rd_addr_count,
  output logic                  notification_mode,
  input  logic                  write_done,
  input  logic                  read_done,
  output logic                  busy,
  output logic                  cmd_error,
  output logic [15:0]           cmd_count
);

`ifdef CMD_CHECKSUM_EN
  localparam int N = 5;
`else
  localparam int N = 4;
`endif
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, HDR, CHECK, ISSUE, WAIT, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [2:0]    idx;
  logic [7:0]    op_q;
  logic          notif_q;
  logic [4:0]    bs_q, be_q;
  logic [15:0]   as_q, ac_q;
  logic [TW-1:0] wait_cnt;
  logic          accept, last_idx, hdr_ok, done_match, set_err;
  logic          csum_ok;
  logic          unused_bits;

  // Reserved header bits carry no meaning for this block.
  assign unused_bits = ^{s_axis_tdata[7:1], s_axis_tdata[15:10]};

  assign accept     = s_axis_tvalid && s_axis_tready;
  assign last_idx   = (idx == 3'(N - 1));
  assign done_match = ((op_q == 8'h01) && write_done) || ((op_q == 8'h02) && read_done);
  assign hdr_ok     = ((op_q == 8'h01) || (op_q == 8'h02)) && (bs_q <= be_q) && csum_ok;

`ifdef CMD_CHECKSUM_EN
  // Running XOR over all header words; a correct w4 folds the total to zero.
  logic [15:0] csum_q;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      csum_q <= '0;
    end else if (accept && state_q == IDLE) begin
      csum_q <= s_axis_tdata[15:0];
    end else if (accept && state_q == HDR) begin
      csum_q <= csum_q ^ s_axis_tdata[15:0];
    end
  end
  assign csum_ok = (csum_q == 16'h0000);
`else
  assign csum_ok = 1'b1;
`endif

  always_comb begin
    state_d          = state_q;
    set_err          = 1'b0;
    s_axis_tready    = 1'b0;
    busy             = 1'b1;
    Instruction_code = 8'h00;
    case (state_q)
      IDLE: begin
        s_axis_tready = 1'b1;
        busy          = 1'b0;
        if (accept) begin
          if (s_axis_tlast) set_err = 1'b1;
          else              state_d = HDR;
        end
      end
      HDR: begin
        s_axis_tready = 1'b1;
        if (accept) begin
          if (last_idx) begin
            if (s_axis_tlast) begin
              state_d = CHECK;
            end else begin
              set_err = 1'b1;
              state_d = DRAIN;
            end
          end else if (s_axis_tlast) begin
            set_err = 1'b1;
            state_d = IDLE;
          end
        end
      end
      CHECK: begin
        if (hdr_ok) begin
          state_d = ISSUE;
        end else begin
          set_err = 1'b1;
          state_d = IDLE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // Drop the code in the done cycle so the engine cannot relaunch.
        Instruction_code = done_match ? 8'h00 : op_q;
        if (done_match) begin
          state_d = IDLE;
        end else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          set_err = 1'b1;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        s_axis_tready = 1'b1;
        if (accept && s_axis_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q           <= IDLE;
      idx               <= '0;
      op_q              <= '0;
      notif_q           <= 1'b0;
      bs_q              <= '0;
      be_q              <= '0;
      as_q              <= '0;
      ac_q              <= '0;
      wait_cnt          <= '0;
      cmd_error         <= 1'b0;
      cmd_count         <= '0;
      wr_bram_start     <= '0;
      wr_bram_end       <= '0;
      wr_addr_start     <= '0;
      wr_addr_count     <= '0;
      rd_bram_start     <= '0;
      rd_bram_end       <= '0;
      rd_addr_start     <= '0;
      rd_addr_count     <= '0;
      notification_mode <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_d != HDR) idx <= '0;
      else if (accept)    idx <= idx + 3'd1;

      if (accept && (state_q == IDLE || state_q == HDR)) begin
        case (idx)
          3'd0: begin
            op_q    <= s_axis_tdata[15:8];
            notif_q <= s_axis_tdata[0];
          end
          3'd1: begin
            bs_q <= s_axis_tdata[4:0];
            be_q <= s_axis_tdata[9:5];
          end
          3'd2:    as_q <= s_axis_tdata[15:0];
          3'd3:    ac_q <= s_axis_tdata[15:0];
          default: ;
        endcase
      end

      // A new header clears the flag, but an error on that same beat wins.
      if (accept && state_q == IDLE) cmd_error <= 1'b0;
      if (set_err)                   cmd_error <= 1'b1;

      if (state_q == ISSUE) begin
        if (op_q == 8'h01) begin
          wr_bram_start     <= bs_q;
          wr_bram_end       <= be_q;
          wr_addr_start     <= as_q;
          wr_addr_count     <= ac_q;
          notification_mode <= 1'b0;
        end else begin
          rd_bram_start     <= bs_q[2:0];
          rd_bram_end       <= be_q[2:0];
          rd_addr_start     <= as_q;
          rd_addr_count     <= ac_q;
          notification_mode <= notif_q;
        end
      end

      if (state_q == ISSUE)     wait_cnt <= '0;
      else if (state_q == WAIT) wait_cnt <= wait_cnt + TW'(1);

      if (state_q == WAIT && done_match) cmd_count <= cmd_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_axis_cmd_parser.sv
// tb/tb_axis_cmd_parser.sv - scoreboard bench for axis_cmd_parser
// Expectations are queued by the stimulus; a negedge monitor pops them on DUT events.
module tb_axis_cmd_parser;

  localparam int EV_ISSUE  = 1;
  localparam int EV_DONE   = 2;
  localparam int EV_RETIRE = 3;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [7:0]  Instruction_code;
  logic [4:0]  wr_bram_start, wr_bram_end;
  logic [15:0] wr_addr_start, wr_addr_count;
  logic [2:0]  rd_bram_start, rd_bram_end;
  logic [15:0] rd_addr_start, rd_addr_count;
  logic        notification_mode, write_done, read_done, busy, cmd_error;
  logic [15:0] cmd_count;

  axis_cmd_parser #(.DATA_WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .Instruction_code(Instruction_code),
    .wr_bram_start(wr_bram_start), .wr_bram_end(wr_bram_end),
    .wr_addr_start(wr_addr_start), .wr_addr_count(wr_addr_count),
    .rd_bram_start(rd_bram_start), .rd_bram_end(rd_bram_end),
    .rd_addr_start(rd_addr_start), .rd_addr_count(rd_addr_count),
    .notification_mode(notification_mode),
    .write_done(write_done), .read_done(read_done),
    .busy(busy), .cmd_error(cmd_error), .cmd_count(cmd_count)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int          kind;
    int          cyc;
    logic [7:0]  code;
    logic        err;
    logic [15:0] cnt;
    logic [4:0]  bs, be;
    logic [15:0] a_s, a_c;
    logic        nt;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc = 0;
  int   t_last = 0;
  logic [7:0] prev_code = 8'h00;
  logic       prev_busy = 1'b0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_issue(input logic [7:0] code, input int c, input logic [4:0] bs,
                            input logic [4:0] be, input logic [15:0] a_s,
                            input logic [15:0] a_c, input logic nt);
    exp_t e;
    e = '{kind: EV_ISSUE, cyc: c, code: code, err: 1'b0, cnt: 16'h0,
          bs: bs, be: be, a_s: a_s, a_c: a_c, nt: nt};
    sb.push_back(e);
  endtask

  task automatic push_done(input logic [7:0] code);
    exp_t e;
    e = '{kind: EV_DONE, cyc: -1, code: code, err: 1'b0, cnt: 16'h0,
          bs: 5'h0, be: 5'h0, a_s: 16'h0, a_c: 16'h0, nt: 1'b0};
    sb.push_back(e);
  endtask

  task automatic push_retire(input logic err, input logic [15:0] cnt, input int c);
    exp_t e;
    e = '{kind: EV_RETIRE, cyc: c, code: 8'h00, err: err, cnt: cnt,
          bs: 5'h0, be: 5'h0, a_s: 16'h0, a_c: 16'h0, nt: 1'b0};
    sb.push_back(e);
  endtask

  task automatic ev(input int kind);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
    end else begin
      e = sb.pop_front();
      chk("event_kind", kind, e.kind);
      if (kind == e.kind) begin
        case (kind)
          EV_ISSUE: begin
            chk("issue_code", Instruction_code, e.code);
            chk("issue_cycle", cyc, e.cyc);
            if (e.code == 8'h01) begin
              chk("wr_bram_start", wr_bram_start, e.bs);
              chk("wr_bram_end", wr_bram_end, e.be);
              chk("wr_addr_start", wr_addr_start, e.a_s);
              chk("wr_addr_count", wr_addr_count, e.a_c);
            end else begin
              chk("rd_bram_start", rd_bram_start, e.bs[2:0]);
              chk("rd_bram_end", rd_bram_end, e.be[2:0]);
              chk("rd_addr_start", rd_addr_start, e.a_s);
              chk("rd_addr_count", rd_addr_count, e.a_c);
            end
            chk("notification_mode", notification_mode, e.nt);
          end
          EV_DONE: chk("done_cycle_code", Instruction_code, e.code);
          default: begin
            chk("retire_cmd_error", cmd_error, e.err);
            chk("retire_cmd_count", cmd_count, e.cnt);
            chk("retire_code", Instruction_code, 8'h00);
            if (e.cyc >= 0) chk("retire_cycle", cyc, e.cyc);
          end
        endcase
      end
    end
  endtask

  always @(negedge aclk) begin
    if (Instruction_code != 8'h00 && prev_code == 8'h00) ev(EV_ISSUE);
    if ((write_done || read_done) && busy)               ev(EV_DONE);
    if (prev_busy && !busy)                              ev(EV_RETIRE);
    prev_code <= Instruction_code;
    prev_busy <= busy;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [15:0] d, input logic l);
    int k;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = l;
    k = 0;
    while (!s_axis_tready && k < 32) begin
      @(posedge aclk);
      #1;
      k++;
    end
    if (k >= 32) begin
      n_vec++;
      n_miss++;
      $display("FAIL tready_timeout: got 0 expected 1 (cycle %0d)", cyc);
    end
    t_last = cyc;
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] w0, input logic [15:0] w1,
                          input logic [15:0] w2, input logic [15:0] w3);
    send_beat(w0, 1'b0);
    send_beat(w1, 1'b0);
    send_beat(w2, 1'b0);
`ifdef CMD_CHECKSUM_EN
    send_beat(w3, 1'b0);
    send_beat(w0 ^ w1 ^ w2 ^ w3, 1'b1);
`else
    send_beat(w3, 1'b1);
`endif
  endtask

  task automatic pulse(input logic wd, input logic rd);
    write_done = wd;
    read_done  = rd;
    @(posedge aclk);
    #1;
    write_done = 1'b0;
    read_done  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected summary");
    $fatal(1);
  end

  initial begin
    aresetn       = 1'b0;
    s_axis_tdata  = 16'h0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    write_done    = 1'b0;
    read_done     = 1'b0;
    idle(3);
    chk("rst_code", Instruction_code, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmd_error", cmd_error, 1'b0);
    chk("rst_cmd_count", cmd_count, 16'h0);
    chk("rst_wr_addr_count", wr_addr_count, 16'h0);
    chk("rst_rd_addr_count", rd_addr_count, 16'h0);
    chk("rst_tready", s_axis_tready, 1'b1);
    aresetn = 1'b1;
    idle(2);

    // Write: banks 0..3, 512 words
    send_hdr(16'h0100, 16'h0060, 16'h0000, 16'h0200);
    push_issue(8'h01, t_last + 3, 5'd0, 5'd3, 16'h0000, 16'd512, 1'b0);
    idle(3);
    push_done(8'h00);
    push_retire(1'b0, 16'd1, cyc + 1);
    pulse(1'b1, 1'b0);
    idle(2);

    // Read with notification; stray write_done ignored
    send_hdr(16'h0201, 16'h0021, 16'h0010, 16'h0004);
    push_issue(8'h02, t_last + 3, 5'd1, 5'd1, 16'h0010, 16'h0004, 1'b1);
    idle(3);
    push_done(8'h02);
    pulse(1'b1, 1'b0);
    push_done(8'h00);
    push_retire(1'b0, 16'd2, cyc + 1);
    pulse(1'b0, 1'b1);
    idle(2);
    chk("wr_hold_addr_count", wr_addr_count, 16'd512);
    chk("wr_hold_bram_end", wr_bram_end, 5'd3);

    // Illegal opcode
    send_hdr(16'h0700, 16'h0000, 16'h0000, 16'h0000);
    push_retire(1'b1, 16'd2, t_last + 2);
    idle(4);

    // tlast on second beat
    send_beat(16'h0100, 1'b0);
    send_beat(16'h0060, 1'b1);
    push_retire(1'b1, 16'd2, t_last + 1);
    idle(2);
    chk("short_hdr_busy", busy, 1'b0);
    chk("short_hdr_error", cmd_error, 1'b1);

    // Next header clears the error on its first beat
    send_beat(16'h0100, 1'b0);
    chk("err_clear_first_beat", cmd_error, 1'b0);
    send_beat(16'h0021, 1'b0);
    send_beat(16'h0040, 1'b0);
`ifdef CMD_CHECKSUM_EN
    send_beat(16'h0008, 1'b0);
    send_beat(16'h0169, 1'b1);
`else
    send_beat(16'h0008, 1'b1);
`endif
    push_issue(8'h01, t_last + 3, 5'd1, 5'd1, 16'h0040, 16'h0008, 1'b0);
    idle(3);
    push_done(8'h00);
    push_retire(1'b0, 16'd3, cyc + 1);
    pulse(1'b1, 1'b0);
    idle(2);

    // Over-long packet is drained to its tlast
    send_beat(16'h0100, 1'b0);
    send_beat(16'h0060, 1'b0);
    send_beat(16'h0000, 1'b0);
    send_beat(16'h0200, 1'b0);
    send_beat(16'h1111, 1'b0);
    send_beat(16'h2222, 1'b1);
    push_retire(1'b1, 16'd3, t_last + 1);
    idle(2);

    // Timeout after 8 WAIT cycles
    send_hdr(16'h0100, 16'h0060, 16'h0000, 16'h0200);
    push_issue(8'h01, t_last + 3, 5'd0, 5'd3, 16'h0000, 16'd512, 1'b0);
    push_retire(1'b1, 16'd3, t_last + 11);
    idle(14);

`ifdef CMD_CHECKSUM_EN
    send_beat(16'h0100, 1'b0);
    send_beat(16'h0060, 1'b0);
    send_beat(16'h0000, 1'b0);
    send_beat(16'h0200, 1'b0);
    send_beat(16'hBEEF, 1'b1);
    push_retire(1'b1, 16'd3, t_last + 2);
    idle(3);
`endif

    // Reset during WAIT discards the command
    send_hdr(16'h0201, 16'h0021, 16'h0010, 16'h0004);
    push_issue(8'h02, t_last + 3, 5'd1, 5'd1, 16'h0010, 16'h0004, 1'b1);
    idle(3);
    push_retire(1'b0, 16'd0, -1);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_code", Instruction_code, 8'h00);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_cmd_count", cmd_count, 16'h0);
    chk("mid_rst_rd_addr_start", rd_addr_start, 16'h0);
    chk("mid_rst_rd_bram_end", rd_bram_end, 3'h0);
    chk("mid_rst_notification", notification_mode, 1'b0);
    chk("mid_rst_wr_addr_count", wr_addr_count, 16'h0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    idle(1);
    pulse(1'b0, 1'b1);
    idle(2);
    chk("post_rst_cmd_count", cmd_count, 16'h0);
    chk("post_rst_busy", busy, 1'b0);

    idle(3);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
